// File: rtl/de2_115_ir_nec_rx.sv
// NEC infrared receive controller with an Avalon-MM slave and a level interrupt.
// Ports:
//   clk, reset_n              system clock, asynchronous active-low reset
//   address/chipselect/read/write/writedata/readdata   Avalon-MM slave
//                             (0 DATA, 1 STATUS w1c, 2 CONTROL, 3 RAW)
//   irq                       level interrupt, IRQ_EN & (VALID | REPEAT)
//   in_port                   demodulated IR input, active-low (0 = mark)
module de2_115_ir_nec_rx #(
    parameter int unsigned TICK_DIV       = 500,
    parameter int unsigned LEAD_MARK_MIN  = 800,
    parameter int unsigned LEAD_MARK_MAX  = 1000,
    parameter int unsigned HDR_SPACE_MIN  = 400,
    parameter int unsigned HDR_SPACE_MAX  = 500,
    parameter int unsigned REP_SPACE_MIN  = 180,
    parameter int unsigned REP_SPACE_MAX  = 270,
    parameter int unsigned BIT_MARK_MIN   = 30,
    parameter int unsigned BIT_MARK_MAX   = 80,
    parameter int unsigned ZERO_SPACE_MIN = 30,
    parameter int unsigned ZERO_SPACE_MAX = 80,
    parameter int unsigned ONE_SPACE_MIN  = 140,
    parameter int unsigned ONE_SPACE_MAX  = 200,
    parameter int unsigned TIMEOUT        = 1200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        in_port
);

    localparam int unsigned CNT_W = 11;
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_REP_STOP
    } state_t;

    function automatic logic in_win(input logic [CNT_W-1:0] c,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

    logic             r_sync1, r_sync2, r_sync_d;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state, w_next;
    logic [4:0]       r_bit_idx;
    logic [31:0]      r_shift, r_data;
    logic             r_valid, r_repeat, r_chkerr, r_overrun;
    logic [2:0]       r_ctrl;

    logic w_tick, w_fall, w_rise, w_en, w_timeout;
    logic w_shift_en, w_shift_bit, w_idx_clr, w_commit, w_rep_set;
    logic w_frame_ok, w_set_valid, w_set_chk, w_wr_status, w_wr_ctrl;
    logic w_unused;

    assign w_tick    = (r_div == DIV_W'(TICK_DIV - 1));
    assign w_fall    = r_sync_d & ~r_sync2;
    assign w_rise    = ~r_sync_d & r_sync2;
    assign w_en      = r_ctrl[0];
    assign w_timeout = (r_cnt >= CNT_W'(TIMEOUT));
    assign w_unused  = ^writedata[31:4];

    // Input synchronizer; flops reset to the idle (space) level so release causes no edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= in_port;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // Tick prescaler and saturating pulse-width counter, cleared on every edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
            r_cnt <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_fall || w_rise)
                r_cnt <= '0;
            else if (w_tick && (r_cnt != CNT_MAX))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // FSM next-state and event decode; edge widths are judged on the pre-clear count.
    always_comb begin
        w_next      = r_state;
        w_shift_en  = 1'b0;
        w_shift_bit = 1'b0;
        w_idx_clr   = 1'b0;
        w_commit    = 1'b0;
        w_rep_set   = 1'b0;
        if ((r_state != S_IDLE) && (!w_en || w_timeout)) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_fall && w_en) w_next = S_LEAD_MARK;
                S_LEAD_MARK: if (w_rise)
                    w_next = in_win(r_cnt, CNT_W'(LEAD_MARK_MIN), CNT_W'(LEAD_MARK_MAX))
                             ? S_LEAD_SPACE : S_IDLE;
                S_LEAD_SPACE: if (w_fall) begin
                    if (in_win(r_cnt, CNT_W'(HDR_SPACE_MIN), CNT_W'(HDR_SPACE_MAX))) begin
                        w_next    = S_BIT_MARK;
                        w_idx_clr = 1'b1;
                    end else if (in_win(r_cnt, CNT_W'(REP_SPACE_MIN), CNT_W'(REP_SPACE_MAX))) begin
                        w_next = S_REP_STOP;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                S_BIT_MARK: if (w_rise)
                    w_next = in_win(r_cnt, CNT_W'(BIT_MARK_MIN), CNT_W'(BIT_MARK_MAX))
                             ? S_BIT_SPACE : S_IDLE;
                S_BIT_SPACE: if (w_fall) begin
                    if (in_win(r_cnt, CNT_W'(ZERO_SPACE_MIN), CNT_W'(ZERO_SPACE_MAX)) ||
                        in_win(r_cnt, CNT_W'(ONE_SPACE_MIN), CNT_W'(ONE_SPACE_MAX))) begin
                        w_shift_en  = 1'b1;
                        w_shift_bit = in_win(r_cnt, CNT_W'(ONE_SPACE_MIN), CNT_W'(ONE_SPACE_MAX));
                        w_next      = (r_bit_idx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                S_STOP_MARK: if (w_rise) begin
                    w_commit = in_win(r_cnt, CNT_W'(BIT_MARK_MIN), CNT_W'(BIT_MARK_MAX));
                    w_next   = S_IDLE;
                end
                S_REP_STOP: if (w_rise) begin
                    w_rep_set = in_win(r_cnt, CNT_W'(BIT_MARK_MIN), CNT_W'(BIT_MARK_MAX));
                    w_next    = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Frame assembly: LSB-first, so the first received bit ends in bit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_idx_clr)
                r_bit_idx <= '0;
            else if (w_shift_en)
                r_bit_idx <= r_bit_idx + 5'd1;
            if (w_shift_en)
                r_shift <= {w_shift_bit, r_shift[31:1]};
        end
    end

    assign w_frame_ok  = !r_ctrl[2] ||
                         ((r_shift[15:8] == ~r_shift[7:0]) && (r_shift[31:24] == ~r_shift[23:16]));
    assign w_set_valid = w_commit & w_frame_ok;
    assign w_set_chk   = w_commit & ~w_frame_ok;
    assign w_wr_status = chipselect & write & (address == 2'd1);
    assign w_wr_ctrl   = chipselect & write & (address == 2'd2);

    // Register file; hardware sets take priority over write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_repeat  <= 1'b0;
            r_chkerr  <= 1'b0;
            r_overrun <= 1'b0;
            r_ctrl    <= '0;
        end else begin
            if (w_set_valid) r_data <= r_shift;
            r_valid   <= w_set_valid | (r_valid & ~(w_wr_status & writedata[0]));
            r_repeat  <= w_rep_set | (r_repeat & ~(w_wr_status & writedata[1]));
            r_chkerr  <= w_set_chk | (r_chkerr & ~(w_wr_status & writedata[2]));
            r_overrun <= (w_set_valid & r_valid) | (r_overrun & ~(w_wr_status & writedata[3]));
            if (w_wr_ctrl) r_ctrl <= writedata[2:0];
        end
    end

    // Registered read data and interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            irq <= r_ctrl[1] & (r_valid | r_repeat);
            if (chipselect && read) begin
                case (address)
                    2'd0:    readdata <= r_data;
                    2'd1:    readdata <= {28'd0, r_overrun, r_chkerr, r_repeat, r_valid};
                    2'd2:    readdata <= {29'd0, r_ctrl};
                    2'd3:    readdata <= {31'd0, r_sync2};
                    default: readdata <= '0;
                endcase
            end
        end
    end

endmodule

// File: doc/de2_115_ir_nec_rx.md
Name: de2_115_ir_nec_rx

Overview:
NEC-protocol infrared receive controller for the DE2-115 SOPC. It samples the demodulated IR receiver output and times the mark and space pulses with a state machine. It assembles 32-bit frames and flags repeat codes, then presents results to the Nios II over an Avalon-MM slave with an interrupt. It replaces CPU bit-banging of the raw IR input port.

Parameters:
TICK_DIV, 500, clk cycles per timing tick (10 us at 50 MHz)
LEAD_MARK_MIN, 800, minimum leader mark in ticks; LEAD_MARK_MAX, 1000
HDR_SPACE_MIN, 400, minimum data-header space in ticks; HDR_SPACE_MAX, 500
REP_SPACE_MIN, 180, minimum repeat-header space in ticks; REP_SPACE_MAX, 270
BIT_MARK_MIN, 30, minimum bit/stop mark in ticks; BIT_MARK_MAX, 80
ZERO_SPACE_MIN, 30, minimum logic-0 space in ticks; ZERO_SPACE_MAX, 80
ONE_SPACE_MIN, 140, minimum logic-1 space in ticks; ONE_SPACE_MAX, 200
TIMEOUT, 1200, maximum ticks in any one level before abort

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  Avalon word address
chipselect  in  1  Avalon select
read  in  1  read strobe
write  in  1  write strobe
writedata  in  32  write data
readdata  out  32  registered read data
irq  out  1  level interrupt
in_port  in  1  IR receiver output, active-low (idle high = space)

Behaviour:
- Clock and reset: single clock clk; reset_n asynchronous, active-low, clears all state.
- in_port passes through a 2-flop synchronizer. A mark is synchronized level 0.
- Tick prescaler counts 0..TICK_DIV-1 and emits a 1-cycle tick. Pulse counter is 11 bits, saturating at 2047, increments on tick and clears on every synchronized edge.
- Registers (word address):
  - 0 DATA, RO: last frame, first received bit in bit 0.
  - 1 STATUS: bit0 VALID, bit1 REPEAT, bit2 CHKERR, bit3 OVERRUN. Writing 1 to a bit clears it.
  - 2 CONTROL, RW: bit0 EN, bit1 IRQ_EN, bit2 CHK_EN.
  - 3 RAW, RO: bit0 synchronized level; bits 31:1 are 0.
- Reads: readdata updates on the clock after chipselect&read, giving 1-cycle latency. Unused bits read 0. readdata holds its value otherwise.
- Writes to RO addresses are ignored.
- Reset values: readdata=0, irq=0, DATA=0, STATUS=0, CONTROL=0, state=IDLE, counters=0.
- irq = IRQ_EN & (VALID | REPEAT), registered.
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_STOP.
  - IDLE -> LEAD_MARK on a falling edge when EN=1.
  - LEAD_MARK, on rising edge: go to LEAD_SPACE if count is within the leader-mark window, else IDLE.
  - LEAD_SPACE, on falling edge: header window -> BIT_MARK with bit index 0; repeat window -> REP_STOP; otherwise IDLE.
  - BIT_MARK, on rising edge: bit-mark window -> BIT_SPACE, else IDLE.
  - BIT_SPACE, on falling edge: zero window shifts in 0, one window shifts in 1, otherwise IDLE. Go to STOP_MARK after index 31, else BIT_MARK.
  - STOP_MARK, on rising edge within the bit-mark window: commit the frame and return to IDLE.
  - REP_STOP, on rising edge within the bit-mark window: set REPEAT and return to IDLE.
  - Any out-of-window edge returns to IDLE with no flag change.
- Timeout: if the counter reaches TIMEOUT in any non-IDLE state, go to IDLE. The partial frame is discarded and no flags change.
- Frame commit:
  - If CHK_EN=1 and (byte1 != ~byte0 or byte3 != ~byte2), set CHKERR; DATA and VALID are unchanged.
  - Otherwise DATA <= frame and VALID <= 1. If VALID was already 1, also set OVERRUN.
- Simultaneous events: a hardware set wins over a write-1-clear of the same bit in the same cycle.
- EN cleared mid-frame: FSM returns to IDLE on the next clock and the partial frame is discarded. Registers keep their values.
- Tick alignment jitter (±1 tick) is absorbed by the windows.

Test Plan:
- Frame 0x00FF40BF (addr 0x00, cmd 0x40), EN=1, IRQ_EN=1, CHK_EN=1, nominal timing -> DATA=0xBF40FF00 wait—bit 0 first: DATA=0xBF40FF00 stored as received bytes [7:0]=0x00, [15:8]=0xFF, [23:16]=0x40, [31:24]=0xBF. VALID=1, irq=1 within 2 cycles of the stop-mark rising edge. Writing 0x1 to STATUS drops irq.
- Repeat burst (9 ms mark, 2.25 ms space, 560 us mark) -> REPEAT=1, DATA unchanged, VALID unchanged.
- Frame 0x00FE40BF with CHK_EN=1 -> CHKERR=1, VALID=0, DATA keeps its previous value. Same frame with CHK_EN=0 -> VALID=1.
- Two valid frames with no STATUS clear between them -> second frame in DATA, OVERRUN=1. A write-1-clear of VALID issued in the same cycle as the second commit leaves VALID=1.
- Stimulus is truncated after 10 bits with the line held idle -> after TIMEOUT ticks the FSM is in IDLE and STATUS=0. A following full frame decodes correctly.
- Reset asserted mid-frame, or EN cleared at bit 16 -> all registers read 0 after reset, or IDLE with no flags after the EN clear. RAW reads the inverse of the mark state with 2-3 cycles of latency.
